issue_queue_mc: RTL and testbench
=================================

// Module: issue_queue_mc
// PURPOSE
//  Multi-channel in-order issue queue between decode and issue_read_operands.
//  - Accepts up to NR_PORTS decoded instructions per cycle; releases up to NR_PORTS per cycle, oldest first.
//  - Checks per-FU readiness, same-cycle FU conflicts and same-cycle RAW hazards before release.
//  - Generalises the single-slot decode->issue handshake to configurable width and depth.
// PARAMETERS
//  NR_PORTS  2   enqueue/issue lanes per cycle (1..4)
//  DEPTH     8   queue entries; power of two, >= NR_PORTS
//  DATA_W    64  opaque payload width (scoreboard entry bits)
//  NR_FU     8   number of functional units; FU id width FU_W = $clog2(NR_FU)
// PORTS
//  clk_i        in   1               clock
//  rst_i        in   1               synchronous reset, active-high
//  flush_i      in   1               drop all queued entries
//  stall_i      in   1               block all issue this cycle
//  in_valid_i   in   NR_PORTS        decode lane valid
//  in_ack_o     out  NR_PORTS        decode lane accepted
//  in_data_i    in   NR_PORTS*DATA_W payload per lane
//  in_fu_i      in   NR_PORTS*FU_W   target FU per lane
//  in_rd_i      in   NR_PORTS*5      destination register per lane
//  in_rs1_i     in   NR_PORTS*5      source 1 per lane
//  in_rs2_i     in   NR_PORTS*5      source 2 per lane
//  fu_ready_i   in   NR_FU           FU can accept an op this cycle
//  iss_valid_o  out  NR_PORTS        issue lane valid (lane 0 = oldest)
//  iss_data_o   out  NR_PORTS*DATA_W payload per issue lane
//  iss_fu_o     out  NR_PORTS*FU_W   FU per issue lane
//  count_o      out  $clog2(DEPTH)+1 current occupancy
//  full_o       out  1               count_o == DEPTH
// BEHAVIOUR
//  - Reset or flush: head = tail = count = 0; all entries invalid.
//    Outputs during/after reset: in_ack_o = 0 while rst_i, iss_valid_o = 0, count_o = 0, full_o = 0.
//  - Flush takes priority over enqueue and issue in the same cycle.
//    No ack and no issue while flush_i = 1.
//  - Enqueue (in-order): lane k is acked iff
//      in_valid_i[k] && all lanes j < k acked && free slots (after this cycle's issues) > k.
//    A valid lane behind a non-acked lane is never acked.
//    Entry written at tail+k (mod DEPTH); tail advances by the ack count.
//  - Issue candidates: entries head+k, k < min(count, NR_PORTS). Lane k issues iff all of:
//    - lanes < k issue;
//    - !stall_i and fu_ready_i[fu];
//    - fu differs from every lane < k issuing this cycle;
//    - neither rs1 nor rs2 equals a nonzero rd of a lane < k issuing this cycle.
//    The first failing lane blocks all younger lanes.
//  - iss_valid_o / iss_data_o / iss_fu_o are combinational from registered queue state.
//    Issue is consumed the same cycle (no iss ready; fu_ready_i is the handshake).
//  - Minimum enqueue-to-issue latency is 1 cycle; an entry enqueued at edge N is visible at N+1.
//  - count_next = count - issued + acked; head wraps mod DEPTH.
//    Full: no ack. Empty: no issue.
//    Simultaneous issue+enqueue at full is allowed: freed slots are usable the same cycle.
//  - rd = 0 never creates a hazard.
// CONFIGURATION
//  ISSUE_QUEUE_BYPASS_EN defined:
//    - When count == 0 and !stall_i, acked lane 0 may issue in the same cycle if fu_ready_i[in_fu_i[0]].
//    - iss lane 0 carries the input payload; the entry is not written to the queue.
//    - Other lanes still wait one cycle.
//  ISSUE_QUEUE_BYPASS_EN undefined:
//    - No bypass path; minimum latency is always 1 cycle.
// TESTING
//  1. Reset: rst_i=1 for 2 cycles with in_valid_i=2'b11 -> in_ack_o=0, iss_valid_o=0, count_o=0.
//  2. Dual issue: enqueue A(fu0,rd=5) and B(fu1,rs1=6), fu_ready=all 1
//     -> next cycle iss_valid_o=2'b11; count_o returns to 0.
//  3. RAW: A(rd=5) and B(rs1=5) queued -> cycle 1: only A issues; cycle 2: B issues.
//     Repeat with A.rd=0 -> both issue together.
//  4. Full + wrap: DEPTH=8, fill 8 entries with fu_ready=0 -> full_o=1, in_ack_o=0.
//     Then set fu_ready=1 with 2 new valid lanes -> 2 issued and 2 acked in the same cycle;
//     count_o stays 8; tail wraps.
//  5. Flush mid-operation: 5 entries queued, flush_i=1 with in_valid_i=2'b11
//     -> next cycle count_o=0, no issue, no ack during flush.
//  6. Bypass (macro defined): empty queue, lane0 valid with fu ready -> iss_valid_o[0]=1 in the same cycle, count_o stays 0.
//     Macro undefined: issue occurs 1 cycle later.

Source files
------------

// File: rtl/issue_queue_mc_if.sv
// Decode/issue bundle for issue_queue_mc: enqueue lanes, FU readiness, issue lanes, occupancy.
// Handshake: a decode lane transfers when in_valid_i[k] && in_ack_o[k]; an issue lane is consumed when iss_valid_o[k] is high.
interface issue_queue_mc_if #(
   parameter int NR_PORTS = 2,
   parameter int DEPTH    = 8,
   parameter int DATA_W   = 64,
   parameter int NR_FU    = 8
);
   localparam int FU_W  = $clog2(NR_FU);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                       flush_i;
   logic                       stall_i;
   logic [NR_PORTS-1:0]        in_valid_i;
   logic [NR_PORTS-1:0]        in_ack_o;
   logic [NR_PORTS*DATA_W-1:0] in_data_i;
   logic [NR_PORTS*FU_W-1:0]   in_fu_i;
   logic [NR_PORTS*5-1:0]      in_rd_i;
   logic [NR_PORTS*5-1:0]      in_rs1_i;
   logic [NR_PORTS*5-1:0]      in_rs2_i;
   logic [NR_FU-1:0]           fu_ready_i;
   logic [NR_PORTS-1:0]        iss_valid_o;
   logic [NR_PORTS*DATA_W-1:0] iss_data_o;
   logic [NR_PORTS*FU_W-1:0]   iss_fu_o;
   logic [CNT_W-1:0]           count_o;
   logic                       full_o;

   modport master (
      output flush_i, stall_i, in_valid_i, in_data_i, in_fu_i, in_rd_i, in_rs1_i, in_rs2_i, fu_ready_i,
      input  in_ack_o, iss_valid_o, iss_data_o, iss_fu_o, count_o, full_o
   );

   modport slave (
      input  flush_i, stall_i, in_valid_i, in_data_i, in_fu_i, in_rd_i, in_rs1_i, in_rs2_i, fu_ready_i,
      output in_ack_o, iss_valid_o, iss_data_o, iss_fu_o, count_o, full_o
   );
endinterface

// File: rtl/issue_queue_mc.sv
// Multi-lane in-order issue queue with FU-readiness, FU-conflict and same-cycle RAW checks.
// Optional same-cycle bypass of lane 0 into an empty queue: define ISSUE_QUEUE_BYPASS_EN.
module issue_queue_mc #(
   parameter int NR_PORTS = 2,
   parameter int DEPTH    = 8,
   parameter int DATA_W   = 64,
   parameter int NR_FU    = 8
) (
   input logic             clk_i,
   input logic             rst_i,
   issue_queue_mc_if.slave bus
);
   localparam int FU_W  = $clog2(NR_FU);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [FU_W-1:0]   fu;
      logic [4:0]        rd;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
   } entry_t;

   entry_t mem_q [DEPTH];
   entry_t mem_d [DEPTH];
   logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   entry_t                     in_lane   [NR_PORTS];
   entry_t                     head_lane [NR_PORTS];
   logic [NR_PORTS-1:0]        q_iss, ack, iss_valid;
   logic [NR_PORTS*DATA_W-1:0] iss_data;
   logic [NR_PORTS*FU_W-1:0]   iss_fu;
   logic [CNT_W-1:0]           n_iss, n_wr, free_slots;
   logic                       iss_chain, ack_chain, hazard, byp;

   always_comb begin
      for (int k = 0; k < NR_PORTS; k++) begin
         in_lane[k].data = bus.in_data_i[k*DATA_W +: DATA_W];
         in_lane[k].fu   = bus.in_fu_i[k*FU_W +: FU_W];
         in_lane[k].rd   = bus.in_rd_i[k*5 +: 5];
         in_lane[k].rs1  = bus.in_rs1_i[k*5 +: 5];
         in_lane[k].rs2  = bus.in_rs2_i[k*5 +: 5];
         head_lane[k]    = mem_q[head_q + IDX_W'(k)];
      end
   end

   // Oldest-first release; the first lane that fails stops every younger lane.
   always_comb begin
      q_iss     = '0;
      n_iss     = '0;
      hazard    = 1'b0;
      iss_chain = !rst_i && !bus.flush_i && !bus.stall_i;
      for (int k = 0; k < NR_PORTS; k++) begin
         hazard = 1'b0;
         for (int j = 0; j < k; j++) begin
            if (head_lane[j].fu == head_lane[k].fu) hazard = 1'b1;
            if (head_lane[j].rd != 5'd0 &&
                (head_lane[j].rd == head_lane[k].rs1 || head_lane[j].rd == head_lane[k].rs2))
               hazard = 1'b1;
         end
         iss_chain = iss_chain && (CNT_W'(k) < count_q) &&
                     bus.fu_ready_i[head_lane[k].fu] && !hazard;
         q_iss[k]  = iss_chain;
         n_iss     = n_iss + CNT_W'(iss_chain);
      end
   end

   // Slots freed by this cycle's issues are reusable by this cycle's enqueues.
   always_comb begin
      ack        = '0;
      free_slots = CNT_W'(DEPTH) - count_q + n_iss;
      ack_chain  = !rst_i && !bus.flush_i;
      for (int k = 0; k < NR_PORTS; k++) begin
         ack_chain = ack_chain && bus.in_valid_i[k] && (free_slots > CNT_W'(k));
         ack[k]    = ack_chain;
      end
   end

   always_comb begin
`ifdef ISSUE_QUEUE_BYPASS_EN
      byp = ack[0] && (count_q == '0) && !bus.stall_i && bus.fu_ready_i[in_lane[0].fu];
`else
      byp = 1'b0;
`endif
   end

   always_comb begin
      iss_valid = q_iss;
      iss_data  = '0;
      iss_fu    = '0;
      for (int k = 0; k < NR_PORTS; k++) begin
         iss_data[k*DATA_W +: DATA_W] = head_lane[k].data;
         iss_fu[k*FU_W +: FU_W]       = head_lane[k].fu;
      end
      if (byp) begin
         iss_valid[0]          = 1'b1;
         iss_data[DATA_W-1:0]  = in_lane[0].data;
         iss_fu[FU_W-1:0]      = in_lane[0].fu;
      end
   end

   // A bypassed lane 0 is never written; the remaining acked lanes pack from tail.
   always_comb begin
      mem_d = mem_q;
      n_wr  = '0;
      for (int k = 0; k < NR_PORTS; k++) begin
         if (ack[k] && !(byp && k == 0)) begin
            mem_d[tail_q + n_wr[IDX_W-1:0]] = in_lane[k];
            n_wr = n_wr + CNT_W'(1);
         end
      end
      head_d  = head_q + n_iss[IDX_W-1:0];
      tail_d  = tail_q + n_wr[IDX_W-1:0];
      count_d = count_q - n_iss + n_wr;
      if (bus.flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   assign bus.in_ack_o    = ack;
   assign bus.iss_valid_o = iss_valid;
   assign bus.iss_data_o  = iss_data;
   assign bus.iss_fu_o    = iss_fu;
   assign bus.count_o     = count_q;
   assign bus.full_o      = (count_q == CNT_W'(DEPTH));
endmodule

// File: tb/tb_issue_queue_mc.sv
// Directed bench for issue_queue_mc: reset, dual issue, RAW/FU hazards, full+wrap, flush, bypass.
module tb_issue_queue_mc;
   localparam int NP    = 2;
   localparam int DEPTH = 8;
   localparam int DW    = 64;
   localparam int NFU   = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_pass   = 0;
   int   n_checks = 0;
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   issue_queue_mc_if #(.NR_PORTS(NP), .DEPTH(DEPTH), .DATA_W(DW), .NR_FU(NFU)) bus ();

   issue_queue_mc #(.NR_PORTS(NP), .DEPTH(DEPTH), .DATA_W(DW), .NR_FU(NFU)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic set_lane(input int k, input logic [63:0] d, input logic [2:0] fu,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      bus.in_valid_i[k]         = 1'b1;
      bus.in_data_i[k*DW +: DW] = d;
      bus.in_fu_i[k*3 +: 3]     = fu;
      bus.in_rd_i[k*5 +: 5]     = rd;
      bus.in_rs1_i[k*5 +: 5]    = rs1;
      bus.in_rs2_i[k*5 +: 5]    = rs2;
   endtask

   task automatic idle();
      bus.in_valid_i = '0;
   endtask

   task automatic check_pair_issue(input string tag);
      logic [DW-1:0] e0, e1;
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      check({tag, "_v"},  bus.iss_valid_o, 2'b11);
      check({tag, "_d0"}, bus.iss_data_o[63:0], e0);
      check({tag, "_d1"}, bus.iss_data_o[127:64], e1);
   endtask

   initial begin
      rst = 1'b1;
      bus.flush_i = 1'b0;
      bus.stall_i = 1'b0;
      bus.fu_ready_i = '1;
      bus.in_data_i = '0; bus.in_fu_i = '0; bus.in_rd_i = '0; bus.in_rs1_i = '0; bus.in_rs2_i = '0;
      set_lane(0, 64'hdead, 3'd0, 5'd1, 5'd0, 5'd0);
      set_lane(1, 64'hbeef, 3'd1, 5'd2, 5'd0, 5'd0);
      tick(); tick();
      check("rst_ack",   bus.in_ack_o, 2'b00);
      check("rst_iss",   bus.iss_valid_o, 2'b00);
      check("rst_count", bus.count_o, 0);
      check("rst_full",  bus.full_o, 0);

      // Dual issue
      rst = 1'b0; bus.stall_i = 1'b1;
      set_lane(0, 64'hA0, 3'd0, 5'd5, 5'd0, 5'd0);
      set_lane(1, 64'hB0, 3'd1, 5'd7, 5'd6, 5'd0);
      settle();
      check("dual_ack", bus.in_ack_o, 2'b11);
      tick(); idle(); bus.stall_i = 1'b0; settle();
      check("dual_count", bus.count_o, 2);
      check("dual_iss",   bus.iss_valid_o, 2'b11);
      check("dual_d0",    bus.iss_data_o[63:0], 64'hA0);
      check("dual_d1",    bus.iss_data_o[127:64], 64'hB0);
      check("dual_fu1",   bus.iss_fu_o[5:3], 3'd1);
      tick(); settle();
      check("dual_empty", bus.count_o, 0);
      check("dual_idle",  bus.iss_valid_o, 2'b00);

      // RAW: B.rs1 == A.rd
      bus.stall_i = 1'b1;
      set_lane(0, 64'h1A, 3'd0, 5'd5, 5'd0, 5'd0);
      set_lane(1, 64'h1B, 3'd1, 5'd0, 5'd5, 5'd0);
      tick(); idle(); bus.stall_i = 1'b0; settle();
      check("raw_iss1", bus.iss_valid_o, 2'b01);
      check("raw_d1",   bus.iss_data_o[63:0], 64'h1A);
      tick(); settle();
      check("raw_iss2",  bus.iss_valid_o, 2'b01);
      check("raw_d2",    bus.iss_data_o[63:0], 64'h1B);
      check("raw_count", bus.count_o, 1);
      tick(); settle();
      check("raw_empty", bus.count_o, 0);

      // rd = 0 never hazards
      bus.stall_i = 1'b1;
      set_lane(0, 64'h2A, 3'd0, 5'd0, 5'd0, 5'd0);
      set_lane(1, 64'h2B, 3'd1, 5'd3, 5'd0, 5'd0);
      tick(); idle(); bus.stall_i = 1'b0; settle();
      check("rd0_iss", bus.iss_valid_o, 2'b11);
      tick(); settle();
      check("rd0_empty", bus.count_o, 0);

      // Same-FU conflict
      bus.stall_i = 1'b1;
      set_lane(0, 64'h3A, 3'd2, 5'd0, 5'd0, 5'd0);
      set_lane(1, 64'h3B, 3'd2, 5'd0, 5'd0, 5'd0);
      tick(); idle(); bus.stall_i = 1'b0; settle();
      check("fuc_iss1", bus.iss_valid_o, 2'b01);
      tick(); settle();
      check("fuc_iss2", bus.iss_valid_o, 2'b01);
      check("fuc_d2",   bus.iss_data_o[63:0], 64'h3B);
      tick(); settle();

      // Head FU not ready blocks the younger lane too
      bus.stall_i = 1'b1;
      set_lane(0, 64'h4A, 3'd2, 5'd0, 5'd0, 5'd0);
      set_lane(1, 64'h4B, 3'd3, 5'd0, 5'd0, 5'd0);
      tick(); idle(); bus.stall_i = 1'b0; bus.fu_ready_i = 8'b0000_1000; settle();
      check("fur_block", bus.iss_valid_o, 2'b00);
      bus.stall_i = 1'b1; bus.fu_ready_i = '1; settle();
      check("stall_block", bus.iss_valid_o, 2'b00);
      bus.stall_i = 1'b0; settle();
      check("fur_go", bus.iss_valid_o, 2'b11);
      tick(); settle();
      check("fur_empty", bus.count_o, 0);

      // Fill to full with no FU ready, then issue+enqueue at full
      bus.fu_ready_i = '0;
      for (int c = 0; c < 4; c++) begin
         set_lane(0, 64'h40 + 64'(2*c), 3'd0, 5'd0, 5'd0, 5'd0);
         set_lane(1, 64'h41 + 64'(2*c), 3'd1, 5'd0, 5'd0, 5'd0);
         settle();
         check("fill_ack", bus.in_ack_o, 2'b11);
         exp_q.push_back(64'h40 + 64'(2*c));
         exp_q.push_back(64'h41 + 64'(2*c));
         tick();
      end
      set_lane(0, 64'h48, 3'd0, 5'd0, 5'd0, 5'd0);
      set_lane(1, 64'h49, 3'd1, 5'd0, 5'd0, 5'd0);
      settle();
      check("full_flag",  bus.full_o, 1);
      check("full_count", bus.count_o, 8);
      check("full_noack", bus.in_ack_o, 2'b00);
      check("full_noiss", bus.iss_valid_o, 2'b00);
      bus.fu_ready_i = '1; settle();
      check("full_ack", bus.in_ack_o, 2'b11);
      check_pair_issue("full_iss");
      exp_q.push_back(64'h48);
      exp_q.push_back(64'h49);
      tick(); idle(); settle();
      check("wrap_count", bus.count_o, 8);
      check("wrap_full",  bus.full_o, 1);
      for (int c = 0; c < 4; c++) begin
         check_pair_issue("drain");
         tick(); settle();
      end
      check("drain_count", bus.count_o, 0);
      check("drain_left",  exp_q.size(), 0);

      // Flush with 5 entries queued
      bus.fu_ready_i = '0;
      set_lane(0, 64'h50, 3'd0, 5'd0, 5'd0, 5'd0);
      set_lane(1, 64'h51, 3'd1, 5'd0, 5'd0, 5'd0);
      tick();
      set_lane(0, 64'h52, 3'd0, 5'd0, 5'd0, 5'd0);
      set_lane(1, 64'h53, 3'd1, 5'd0, 5'd0, 5'd0);
      tick();
      idle(); set_lane(0, 64'h54, 3'd0, 5'd0, 5'd0, 5'd0);
      tick(); idle(); settle();
      check("pre_flush_count", bus.count_o, 5);
      bus.flush_i = 1'b1; bus.fu_ready_i = '1;
      set_lane(0, 64'h55, 3'd0, 5'd0, 5'd0, 5'd0);
      set_lane(1, 64'h56, 3'd1, 5'd0, 5'd0, 5'd0);
      settle();
      check("flush_noack", bus.in_ack_o, 2'b00);
      check("flush_noiss", bus.iss_valid_o, 2'b00);
      tick(); bus.flush_i = 1'b0; idle(); settle();
      check("flush_count", bus.count_o, 0);
      check("flush_iss",   bus.iss_valid_o, 2'b00);
      bus.stall_i = 1'b1;
      set_lane(0, 64'h57, 3'd4, 5'd0, 5'd0, 5'd0);
      settle();
      check("post_flush_ack", bus.in_ack_o, 2'b01);
      tick(); idle(); bus.stall_i = 1'b0; settle();
      check("post_flush_iss", bus.iss_valid_o, 2'b01);
      check("post_flush_d",   bus.iss_data_o[63:0], 64'h57);
      tick(); settle();

      // Lane 0 into an empty queue
      set_lane(0, 64'h66, 3'd3, 5'd0, 5'd0, 5'd0);
      settle();
      check("byp_ack", bus.in_ack_o, 2'b01);
`ifdef ISSUE_QUEUE_BYPASS_EN
      check("byp_iss", bus.iss_valid_o, 2'b01);
      check("byp_d",   bus.iss_data_o[63:0], 64'h66);
      check("byp_fu",  bus.iss_fu_o[2:0], 3'd3);
      tick(); idle(); settle();
      check("byp_count", bus.count_o, 0);
      check("byp_idle",  bus.iss_valid_o, 2'b00);
`else
      check("nobyp_iss0", bus.iss_valid_o, 2'b00);
      tick(); idle(); settle();
      check("nobyp_iss1",  bus.iss_valid_o, 2'b01);
      check("nobyp_d",     bus.iss_data_o[63:0], 64'h66);
      check("nobyp_count", bus.count_o, 1);
      tick(); settle();
      check("nobyp_empty", bus.count_o, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
